hazard_control_unit: RTL and testbench
======================================

Name: hazard_control_unit

Overview:
Parametrised next-generation hazard/stall controller for the 5-stage MIPS pipeline. It detects load-use hazards in the EX and optionally MEM stages, ignoring register $0 and unused source fields. It tracks a multi-cycle multiply/divide unit (MDU) with a busy counter and stalls dependent HI/LO instructions. It stretches control-transfer flushes over a configurable number of cycles and keeps a saturating stall-cycle performance counter.

Parameters:
REG_W, 5, register-specifier width.
LOAD_STAGES, 2, number of stages checked for load-use: 1 = EX only, 2 = EX and MEM.
MDU_LAT, 4, MDU latency in cycles (legal range 1..15).
FLUSH_CYCLES, 1, cycles flush is held after a redirect (legal range 1..3).
CNT_W, 16, width of the stall-cycle counter.

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
id_rs  in  REG_W  rs field of the instruction in IF/ID
id_rt  in  REG_W  rt field of the instruction in IF/ID
id_uses_rs  in  1  ID instruction reads rs
id_uses_rt  in  1  ID instruction reads rt
id_mdu_dep  in  1  ID instruction is mfhi/mflo/mult/div (depends on the MDU)
ex_dst  in  REG_W  destination register of the instruction in ID/EX
ex_mem_read  in  1  ID/EX instruction is a load
mem_dst  in  REG_W  destination register of the instruction in EX/MEM
mem_mem_read  in  1  EX/MEM instruction is a load
mdu_start  in  1  MDU operation issued from EX this cycle
branch_taken  in  1  taken branch resolved this cycle
jump  in  2  jump type; non-zero = jump
stat_clear  in  1  clears stall_cycles
pc_write  out  1  PC load enable
if_id_write  out  1  IF/ID load enable
stall_info  out  1  insert bubble (zero control) into ID/EX
flush  out  1  squash IF/ID
mdu_busy  out  1  MDU counter non-zero
stall_cycles  out  CNT_W  saturating count of hazard-stall cycles

Behaviour:
- Reset is synchronous: on a clk edge with reset=1, mdu_cnt, flush_cnt and stall_cycles go to 0.
- While reset=1, outputs are forced: pc_write=0, if_id_write=0, stall_info=1, flush=0, mdu_busy=0.
- Load hazard (lh):
  - (ex_mem_read & ex_dst!=0 & ((id_uses_rs & ex_dst==id_rs) | (id_uses_rt & ex_dst==id_rt)))
  - OR, only when LOAD_STAGES==2, the same expression using mem_mem_read/mem_dst.
- MDU hazard (mh): id_mdu_dep & (mdu_start | mdu_cnt>1).
- mdu_cnt (4-bit):
  - mdu_start loads MDU_LAT on the next edge, with priority over decrement and regardless of the current value.
  - Otherwise it decrements while non-zero.
  - mdu_busy = (mdu_cnt != 0).
- Redirect: redir = branch_taken | (jump != 0).
  - flush = redir | (flush_cnt != 0).
  - On redir, flush_cnt loads FLUSH_CYCLES-1; otherwise it decrements while non-zero.
  - A redirect inside an active window restarts the window.
- Output priority: reset > flush > stall.
  - Flush active: pc_write=1, if_id_write=1, stall_info=1; lh and mh are ignored because the ID instruction is squashed.
  - Else if (lh | mh): pc_write=0, if_id_write=0, stall_info=1.
  - Else: pc_write=1, if_id_write=1, stall_info=0.
- All control outputs are combinational from the inputs and the registered counters; no added latency.
- stall_cycles:
  - Increments on each edge where the hazard-stall branch is selected (not flush, not reset).
  - Saturates at all-ones.
  - stat_clear forces 0 on the edge and overrides increment.

Test Plan:
- Load-use: ex_mem_read=1, ex_dst=8, id_rs=8, id_uses_rs=1 -> pc_write=0, if_id_write=0, stall_info=1 the same cycle; stall_cycles +1. Repeat with ex_dst=0 -> no stall.
- MEM-stage load: mem_mem_read=1, mem_dst=9, id_rt=9, id_uses_rt=1 -> stall with LOAD_STAGES=2; no stall with LOAD_STAGES=1. Same match with id_uses_rt=0 -> no stall.
- MDU: MDU_LAT=4, mdu_start at T, id_mdu_dep held 1 -> stall in T..T+3, released at T+4; mdu_busy=1 in T+1..T+4 and 0 at T+5.
- Flush stretch: FLUSH_CYCLES=3, branch_taken pulse at T with a load hazard present -> flush=1, stall_info=1, pc_write=1 in T..T+2; a jump=2'b10 pulse at T+1 extends flush through T+3.
- Saturation/clear: CNT_W=4, hold a load hazard 20 cycles -> stall_cycles sticks at 15. stat_clear asserted together with a hazard -> stall_cycles=0 next cycle.
- Reset mid-operation: reset asserted at T+1 after mdu_start at T -> mdu_busy=0 and flush=0; at T+2, counters are 0 and no MDU stall remains.

Source files
------------

// File: rtl/hazard_control_unit.sv
// Hazard/stall controller for the 5-stage MIPS pipeline: load-use and MDU
// interlocks, stretched redirect flushes and a saturating stall-cycle counter.
module hazard_control_unit #(
  parameter int REG_W        = 5,
  parameter int LOAD_STAGES  = 2,
  parameter int MDU_LAT      = 4,
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_mdu_dep,
  input  logic [REG_W-1:0] ex_dst,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] mem_dst,
  input  logic             mem_mem_read,
  input  logic             mdu_start,
  input  logic             branch_taken,
  input  logic [1:0]       jump,
  input  logic             stat_clear,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             stall_info,
  output logic             flush,
  output logic             mdu_busy,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam logic [3:0]       MDU_LOAD   = 4'(MDU_LAT);
  localparam logic [1:0]       FLUSH_LOAD = 2'(FLUSH_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [REG_W-1:0] REG_ZERO   = {REG_W{1'b0}};

  // A load only hurts if it writes a real register that the ID instruction reads.
  function automatic logic load_match(
    input logic             is_load,
    input logic [REG_W-1:0] dst,
    input logic [REG_W-1:0] rs,
    input logic [REG_W-1:0] rt,
    input logic             uses_rs,
    input logic             uses_rt
  );
    return is_load & (dst != REG_ZERO) &
           ((uses_rs & (dst == rs)) | (uses_rt & (dst == rt)));
  endfunction

  logic [3:0]       mdu_cnt_r;
  logic [3:0]       mdu_cnt_nxt_s;
  logic [1:0]       flush_cnt_r;
  logic [1:0]       flush_cnt_nxt_s;
  logic [CNT_W-1:0] stall_cycles_r;
  logic [CNT_W-1:0] stall_cycles_nxt_s;
  logic             ex_hit_s;
  logic             mem_hit_s;
  logic             lh_s;
  logic             mh_s;
  logic             redir_s;
  logic             flush_act_s;
  logic             stall_sel_s;

  assign ex_hit_s = load_match(ex_mem_read, ex_dst, id_rs, id_rt, id_uses_rs, id_uses_rt);

  generate
    if (LOAD_STAGES == 2) begin : g_mem_check
      assign mem_hit_s = load_match(mem_mem_read, mem_dst, id_rs, id_rt, id_uses_rs, id_uses_rt);
    end else begin : g_no_mem_check
      assign mem_hit_s = 1'b0;
    end
  endgenerate

  // Hazard and redirect detection; a squashed ID instruction cannot stall.
  always_comb begin
    lh_s        = ex_hit_s | mem_hit_s;
    mh_s        = id_mdu_dep & (mdu_start | (mdu_cnt_r > 4'd1));
    redir_s     = branch_taken | (jump != 2'b00);
    flush_act_s = redir_s | (flush_cnt_r != 2'b00);
    stall_sel_s = ~reset & ~flush_act_s & (lh_s | mh_s);
  end

  // Pipeline control outputs with priority reset > flush > stall.
  always_comb begin
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    stall_info   = 1'b0;
    flush        = 1'b0;
    mdu_busy     = 1'b0;
    stall_cycles = stall_cycles_r;
    if (reset) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      stall_info  = 1'b1;
    end else if (flush_act_s) begin
      stall_info = 1'b1;
      flush      = 1'b1;
      mdu_busy   = (mdu_cnt_r != 4'd0);
    end else if (lh_s | mh_s) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      stall_info  = 1'b1;
      mdu_busy    = (mdu_cnt_r != 4'd0);
    end else begin
      mdu_busy = (mdu_cnt_r != 4'd0);
    end
  end

  // Next-state for the MDU, flush-window and stall-statistics counters.
  always_comb begin
    mdu_cnt_nxt_s      = mdu_cnt_r;
    flush_cnt_nxt_s    = flush_cnt_r;
    stall_cycles_nxt_s = stall_cycles_r;
    if (mdu_start) begin
      mdu_cnt_nxt_s = MDU_LOAD;
    end else if (mdu_cnt_r != 4'd0) begin
      mdu_cnt_nxt_s = mdu_cnt_r - 4'd1;
    end else begin
      mdu_cnt_nxt_s = mdu_cnt_r;
    end
    if (redir_s) begin
      flush_cnt_nxt_s = FLUSH_LOAD;
    end else if (flush_cnt_r != 2'b00) begin
      flush_cnt_nxt_s = flush_cnt_r - 2'b01;
    end else begin
      flush_cnt_nxt_s = flush_cnt_r;
    end
    if (stat_clear) begin
      stall_cycles_nxt_s = CNT_ZERO;
    end else if (stall_sel_s && (stall_cycles_r != CNT_MAX)) begin
      stall_cycles_nxt_s = stall_cycles_r + CNT_ONE;
    end else begin
      stall_cycles_nxt_s = stall_cycles_r;
    end
  end

  // Counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      mdu_cnt_r      <= 4'd0;
      flush_cnt_r    <= 2'b00;
      stall_cycles_r <= CNT_ZERO;
    end else begin
      mdu_cnt_r      <= mdu_cnt_nxt_s;
      flush_cnt_r    <= flush_cnt_nxt_s;
      stall_cycles_r <= stall_cycles_nxt_s;
    end
  end

endmodule

// File: tb/tb_hazard_control_unit.sv
// Self-checking bench for hazard_control_unit: directed vector table, corner
// sequences and randomized traffic against an abstract reference model.
module tb_hazard_control_unit;

  localparam int RW   = 5;
  localparam int MLAT = 4;
  localparam int FC   = 3;
  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic [RW-1:0] id_rs, id_rt, ex_dst, mem_dst;
  logic          id_uses_rs, id_uses_rt, id_mdu_dep, ex_mem_read, mem_mem_read;
  logic          mdu_start, branch_taken, stat_clear;
  logic [1:0]    jump;

  logic          pc_write, if_id_write, stall_info, flush, mdu_busy;
  logic [CW-1:0] stall_cycles;
  logic          pc_write_1, if_id_write_1, stall_info_1, flush_1, mdu_busy_1;
  logic [CW-1:0] stall_cycles_1;

  always #5 clk = ~clk;

  hazard_control_unit #(.REG_W(RW), .LOAD_STAGES(2), .MDU_LAT(MLAT), .FLUSH_CYCLES(FC), .CNT_W(CW)) u_dut (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs),
    .id_uses_rt(id_uses_rt), .id_mdu_dep(id_mdu_dep), .ex_dst(ex_dst), .ex_mem_read(ex_mem_read),
    .mem_dst(mem_dst), .mem_mem_read(mem_mem_read), .mdu_start(mdu_start),
    .branch_taken(branch_taken), .jump(jump), .stat_clear(stat_clear),
    .pc_write(pc_write), .if_id_write(if_id_write), .stall_info(stall_info),
    .flush(flush), .mdu_busy(mdu_busy), .stall_cycles(stall_cycles));

  hazard_control_unit #(.REG_W(RW), .LOAD_STAGES(1), .MDU_LAT(MLAT), .FLUSH_CYCLES(FC), .CNT_W(CW)) u_dut_ex_only (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs),
    .id_uses_rt(id_uses_rt), .id_mdu_dep(id_mdu_dep), .ex_dst(ex_dst), .ex_mem_read(ex_mem_read),
    .mem_dst(mem_dst), .mem_mem_read(mem_mem_read), .mdu_start(mdu_start),
    .branch_taken(branch_taken), .jump(jump), .stat_clear(stat_clear),
    .pc_write(pc_write_1), .if_id_write(if_id_write_1), .stall_info(stall_info_1),
    .flush(flush_1), .mdu_busy(mdu_busy_1), .stall_cycles(stall_cycles_1));

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state: remaining MDU cycles, remaining flush cycles, stall counts.
  int m_mdu   = 0;
  int m_flush = 0;
  int m_cnt[2];

  typedef struct {
    logic [RW-1:0] rs, rt, exd, memd;
    logic          urs, urt, exr, memr, dep;
    logic          exp_st2, exp_st1;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic bit haz_load(input int stages);
    bit ex_h, mem_h;
    ex_h  = ex_mem_read && ex_dst != 0 &&
            ((id_uses_rs && ex_dst == id_rs) || (id_uses_rt && ex_dst == id_rt));
    mem_h = mem_mem_read && mem_dst != 0 &&
            ((id_uses_rs && mem_dst == id_rs) || (id_uses_rt && mem_dst == id_rt));
    return ex_h || (stages == 2 && mem_h);
  endfunction

  task automatic idle();
    reset = 1'b0; id_rs = '0; id_rt = '0; ex_dst = '0; mem_dst = '0;
    id_uses_rs = 1'b0; id_uses_rt = 1'b0; id_mdu_dep = 1'b0; ex_mem_read = 1'b0;
    mem_mem_read = 1'b0; mdu_start = 1'b0; branch_taken = 1'b0; jump = 2'b00; stat_clear = 1'b0;
  endtask

  // One clock: compare both instances against the model, then advance the model.
  task automatic cycle();
    bit redir, fl, mh, st[2];
    @(negedge clk);
    redir = branch_taken || jump != 2'b00;
    fl    = !reset && (redir || m_flush > 0);
    mh    = id_mdu_dep && (mdu_start || m_mdu > 1);
    for (int k = 0; k < 2; k++) st[k] = !reset && !fl && (haz_load(2 - k) || mh);
    check("m_pc",    {15'd0, pc_write},    {15'd0, !reset && !st[0]});
    check("m_ifid",  {15'd0, if_id_write}, {15'd0, !reset && !st[0]});
    check("m_bub",   {15'd0, stall_info},  {15'd0, reset || fl || st[0]});
    check("m_flush", {15'd0, flush},       {15'd0, fl});
    check("m_busy",  {15'd0, mdu_busy},    {15'd0, !reset && m_mdu > 0});
    check("m_pc1",   {15'd0, pc_write_1},  {15'd0, !reset && !st[1]});
    check("m_bub1",  {15'd0, stall_info_1},{15'd0, reset || fl || st[1]});
    check("m_flush1",{15'd0, flush_1},     {15'd0, fl});
    if (!reset) begin
      check("m_cnt",  {12'd0, stall_cycles},   16'(m_cnt[0]));
      check("m_cnt1", {12'd0, stall_cycles_1}, 16'(m_cnt[1]));
    end
    @(posedge clk);
    if (reset) begin
      m_mdu = 0; m_flush = 0; m_cnt[0] = 0; m_cnt[1] = 0;
    end else begin
      m_mdu   = mdu_start ? MLAT : (m_mdu > 0 ? m_mdu - 1 : 0);
      m_flush = redir ? FC - 1 : (m_flush > 0 ? m_flush - 1 : 0);
      for (int k = 0; k < 2; k++) begin
        if (stat_clear) m_cnt[k] = 0;
        else if (st[k] && m_cnt[k] < CMAX) m_cnt[k] = m_cnt[k] + 1;
      end
    end
    #1;
  endtask

  function automatic logic [RW-1:0] pick_reg();
    case ($urandom_range(0, 3))
      0:       return 5'd0;
      1:       return 5'd8;
      2:       return 5'd9;
      default: return 5'($urandom_range(0, 31));
    endcase
  endfunction

  initial begin
    m_cnt[0] = 0;
    m_cnt[1] = 0;
    //             rs     rt     exd    memd   urs   urt   exr   memr  dep   st2   st1
    tbl[0] = '{5'd8,  5'd0,  5'd8,  5'd0,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[1] = '{5'd0,  5'd0,  5'd0,  5'd0,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{5'd0,  5'd9,  5'd0,  5'd9,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{5'd0,  5'd9,  5'd0,  5'd9,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{5'd8,  5'd0,  5'd8,  5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{5'd3,  5'd12, 5'd12, 5'd0,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    tbl[6] = '{5'd0,  5'd0,  5'd0,  5'd0,  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{5'd4,  5'd5,  5'd6,  5'd7,  1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};

    idle();
    reset = 1'b1;
    cycle();
    cycle();
    idle();
    #1;
    check("rst_pc",   {15'd0, pc_write},   16'd1);
    check("rst_bub",  {15'd0, stall_info}, 16'd0);
    check("rst_busy", {15'd0, mdu_busy},   16'd0);
    check("rst_cnt",  {12'd0, stall_cycles}, 16'd0);
    cycle();

    for (int i = 0; i < 8; i++) begin
      idle();
      id_rs = tbl[i].rs; id_rt = tbl[i].rt; ex_dst = tbl[i].exd; mem_dst = tbl[i].memd;
      id_uses_rs = tbl[i].urs; id_uses_rt = tbl[i].urt; ex_mem_read = tbl[i].exr;
      mem_mem_read = tbl[i].memr; id_mdu_dep = tbl[i].dep;
      #1;
      check($sformatf("tbl%0d_pc", i),   {15'd0, pc_write},    {15'd0, ~tbl[i].exp_st2});
      check($sformatf("tbl%0d_ifid", i), {15'd0, if_id_write}, {15'd0, ~tbl[i].exp_st2});
      check($sformatf("tbl%0d_bub", i),  {15'd0, stall_info},  {15'd0, tbl[i].exp_st2});
      check($sformatf("tbl%0d_pc1", i),  {15'd0, pc_write_1},  {15'd0, ~tbl[i].exp_st1});
      cycle();
    end

    // MDU interlock: start at T with a dependent instruction held in ID.
    idle();
    mdu_start = 1'b1; id_mdu_dep = 1'b1;
    for (int i = 0; i <= 5; i++) begin
      if (i > 0) mdu_start = 1'b0;
      #1;
      check($sformatf("mdu_t%0d_pc", i),   {15'd0, pc_write}, {15'd0, !(i <= 3)});
      check($sformatf("mdu_t%0d_busy", i), {15'd0, mdu_busy}, {15'd0, (i >= 1 && i <= 4)});
      cycle();
    end

    // Flush stretch over a live load hazard, window restarted by a jump at T+1.
    idle();
    id_rs = 5'd8; id_uses_rs = 1'b1; ex_dst = 5'd8; ex_mem_read = 1'b1;
    for (int i = 0; i <= 4; i++) begin
      branch_taken = (i == 0);
      jump = (i == 1) ? 2'b10 : 2'b00;
      #1;
      check($sformatf("fl_t%0d_flush", i), {15'd0, flush},      {15'd0, i <= 3});
      check($sformatf("fl_t%0d_pc", i),    {15'd0, pc_write},   {15'd0, i <= 3});
      check($sformatf("fl_t%0d_bub", i),   {15'd0, stall_info}, 16'd1);
      cycle();
    end

    // Saturation and clear of the stall counter.
    idle();
    stat_clear = 1'b1;
    cycle();
    idle();
    id_rs = 5'd8; id_uses_rs = 1'b1; ex_dst = 5'd8; ex_mem_read = 1'b1;
    for (int i = 0; i < 20; i++) cycle();
    check("sat_cnt", {12'd0, stall_cycles}, 16'd15);
    stat_clear = 1'b1;
    cycle();
    stat_clear = 1'b0;
    check("clr_cnt", {12'd0, stall_cycles}, 16'd0);
    cycle();
    check("clr_inc", {12'd0, stall_cycles}, 16'd1);

    // Reset landing one cycle after an MDU start, with a branch pending.
    idle();
    mdu_start = 1'b1;
    cycle();
    idle();
    reset = 1'b1; branch_taken = 1'b1; id_mdu_dep = 1'b1;
    #1;
    check("rstmid_busy",  {15'd0, mdu_busy},   16'd0);
    check("rstmid_flush", {15'd0, flush},      16'd0);
    check("rstmid_pc",    {15'd0, pc_write},   16'd0);
    cycle();
    reset = 1'b0; branch_taken = 1'b0;
    #1;
    check("rstpost_busy", {15'd0, mdu_busy},     16'd0);
    check("rstpost_pc",   {15'd0, pc_write},     16'd1);
    check("rstpost_cnt",  {12'd0, stall_cycles}, 16'd0);
    cycle();

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      reset        = ($urandom_range(0, 39) == 0);
      id_rs        = pick_reg();
      id_rt        = pick_reg();
      ex_dst       = pick_reg();
      mem_dst      = pick_reg();
      id_uses_rs   = 1'($urandom_range(0, 1));
      id_uses_rt   = 1'($urandom_range(0, 1));
      ex_mem_read  = 1'($urandom_range(0, 1));
      mem_mem_read = 1'($urandom_range(0, 1));
      id_mdu_dep   = ($urandom_range(0, 2) == 0);
      mdu_start    = ($urandom_range(0, 7) == 0);
      branch_taken = ($urandom_range(0, 9) == 0);
      jump         = ($urandom_range(0, 9) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      stat_clear   = ($urandom_range(0, 24) == 0);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
